add_seq_ctrl: RTL and testbench

Multi-cycle sequencer that performs WIDTH-bit add/subtract using a single instantiated `adder_4bit` slice, one nibble per clock, least-significant nibble first. It holds operands, routes the carry between slices through a carry register, and presents the result behind a valid/ready handshake. It sits between the ALU operand registers and the result bus, trading latency for area where a full-width adder is too large.

---
 rtl/add_seq_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_add_seq_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/add_seq_ctrl.sv
// rtl/add_seq_ctrl.sv - nibble-serial add/subtract sequencer around one 4-bit adder slice (optional ADD_SEQ_OVERFLOW_EN)

// Plain 4-bit ripple slice; the sequencer reuses this one instance every cycle.
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

module add_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N    = WIDTH / 4;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       slice_sum;
  logic             slice_cout;

  // Pick the operand nibbles for the current index; B is inverted for subtract
  // (the +1 comes from carry_q being seeded with sub at acceptance).
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4] ^ {4{sub_q}};
      end
    end
  end

  adder_4bit u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Next-state and next-output logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    result_d    = result_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          sub_d      = sub;
          carry_d    = sub;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (idx_q == IDXW'(i)) begin
            result_d[4*i +: 4] = slice_sum;
          end
        end
        carry_d = slice_cout;
        if (idx_q == LAST_IDX) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State, operand, carry and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry_out = carry_q;

`ifdef ADD_SEQ_OVERFLOW_EN
  logic ovf_q, ovf_d;
  logic msb_cin;

  // Carry into the MSB recovered from the top slice's own bit-3 sum.
  assign msb_cin = a_nib[3] ^ b_nib[3] ^ slice_sum[3];

  // Capture signed overflow while the most-significant nibble is computed.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == RUN && idx_q == LAST_IDX) begin
      ovf_d = msb_cin ^ slice_cout;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb/tb_add_seq_ctrl.sv - self-checking bench for add_seq_ctrl (vectors, corner sequences, random vs model)

module tb_add_seq_ctrl;

`ifdef ADD_SEQ_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        carry_out;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  add_seq_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vsub;
    logic [15:0] er;
    logic        ec;
    logic        ev;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: arithmetic on whole words, signed rules from operand/result signs.
  function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic ms,
                                output logic [15:0] r, output logic c, output logic v);
    logic [16:0] full;
    if (ms) begin
      full = {1'b0, ma} - {1'b0, mb};
      c    = (ma >= mb);
    end else begin
      full = {1'b0, ma} + {1'b0, mb};
      c    = full[16];
    end
    r = full[15:0];
    if (ms) v = (ma[15] != mb[15]) && (r[15] != ma[15]);
    else    v = (ma[15] == mb[15]) && (r[15] != ma[15]);
    v = v & OVF_EN;
  endfunction

  // Issue one operation, wait for the result, stall, sample, then handshake.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic ts, input int stall,
                       output logic [15:0] r, output logic c, output logic v, output int lat);
    @(negedge clk);
    a = ta; b = tb; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      a = 16'($urandom); b = 16'($urandom);
    end
    repeat (stall) begin
      @(posedge clk); #1;
    end
    r = result; c = carry_out; v = overflow;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_handshake_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  vec_t        vecs[7];
  logic [15:0] r, mr, hold_r;
  logic        c, v, mc, mv;
  int          lat, k;

  initial begin
    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, OVF_EN};
    vecs[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, OVF_EN};
    vecs[6] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_result", {16'b0, result}, 32'd0);
    chk("reset_carry_out", {31'b0, carry_out}, 32'd0);
    chk("reset_overflow", {31'b0, overflow}, 32'd0);

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vsub, 0, r, c, v, lat);
      chk($sformatf("vec%0d_latency", i), lat, 32'd4);
      chk($sformatf("vec%0d_result", i), {16'b0, r}, {16'b0, vecs[i].er});
      chk($sformatf("vec%0d_carry", i), {31'b0, c}, {31'b0, vecs[i].ec});
      chk($sformatf("vec%0d_overflow", i), {31'b0, v}, {31'b0, vecs[i].ev});
    end

    // Backpressure: hold DONE for 5 cycles while inputs churn
    @(negedge clk);
    a = 16'h1234; b = 16'h0FFF; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("run_in_ready", {31'b0, in_ready}, 32'd0);
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("bp_latency", k, 32'd4);
    hold_r = result;
    chk("bp_result", {16'b0, hold_r}, 32'h2233);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom); in_valid = 1'($urandom);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_result_stable", i), {16'b0, result}, {16'b0, hold_r});
      chk($sformatf("bp%0d_in_ready", i), {31'b0, in_ready}, 32'd0);
      chk($sformatf("bp%0d_out_valid", i), {31'b0, out_valid}, 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("bp_in_ready_before_edge", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_in_ready_after", {31'b0, in_ready}, 32'd1);
    chk("bp_out_valid_after", {31'b0, out_valid}, 32'd0);

    // Reset after E2 of an operation
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_result", {16'b0, result}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (6) begin
      @(posedge clk); #1;
      chk("midrst_no_out_valid", {31'b0, out_valid}, 32'd0);
    end
    do_op(16'h00FF, 16'h0001, 1'b0, 0, r, c, v, lat);
    chk("after_rst_latency", lat, 32'd4);
    chk("after_rst_result", {16'b0, r}, 32'h0100);

    // Random operations against the model
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      logic        rs;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 5 == 0) rb = ra;
      rs = 1'($urandom);
      model(ra, rb, rs, mr, mc, mv);
      do_op(ra, rb, rs, int'($urandom_range(0, 3)), r, c, v, lat);
      chk($sformatf("rnd%0d_latency", i), lat, 32'd4);
      chk($sformatf("rnd%0d_result", i), {16'b0, r}, {16'b0, mr});
      chk($sformatf("rnd%0d_carry", i), {31'b0, c}, {31'b0, mc});
      chk($sformatf("rnd%0d_overflow", i), {31'b0, v}, {31'b0, mv});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
